// File: rtl/bus_copy_pkg.sv
// bus_copy_pkg: shared state encoding and size defaults for the bus copy controller
package bus_copy_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int BANK_DEPTH = 1 << DEFAULT_ADDR_WIDTH;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/bus_copy_if.sv
// bus_copy_if: host handshake, direct-load, observation and shared bus signals
interface bus_copy_if import bus_copy_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] count;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] bus;
    logic                  busy;
    logic                  done;
    modport master (
        output start, src, dst, count, load_en, load_addr, data_in, rd_addr,
        input  rd_data, bus, busy, done
    );
    modport slave (
        input  start, src, dst, count, load_en, load_addr, data_in, rd_addr,
        output rd_data, bus, busy, done
    );
endinterface

// File: rtl/reg_bank_4x8.sv
// reg_bank_4x8: register bank with one sync write port, sync clear and two combinational reads
module reg_bank_4x8 import bus_copy_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Clear every entry on reset, otherwise apply the single write port
    always_ff @(posedge clock) begin
        if (reset) mem_q <= '{default: '0};
        else if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/bus_copy_controller.sv
// bus_copy_controller: READ/WRITE sequencer copying bytes between bank entries over a shared bus
module bus_copy_controller import bus_copy_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input logic     clock,
    input logic     reset,
    bus_copy_if.slave bif
);
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] src_ptr_q;
    logic [ADDR_WIDTH-1:0] dst_ptr_q;
    logic [ADDR_WIDTH-1:0] remaining_q;
    logic [DATA_WIDTH-1:0] latch_q;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] src_data;

    reg_bank_4x8 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
        .clock     (clock),
        .reset     (reset),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (src_ptr_q),
        .rdata_a_o (src_data),
        .raddr_b_i (bif.rd_addr),
        .rdata_b_o (bif.rd_data)
    );

    // The bank write port is shared: copy writes in WRITE, host loads only while IDLE
    always_comb begin
        we    = (state_q == IDLE && bif.load_en) || state_q == WRITE;
        waddr = state_q == WRITE ? dst_ptr_q : bif.load_addr;
        wdata = state_q == WRITE ? latch_q : bif.data_in;
    end

    assign bif.bus  = state_q == READ ? src_data : state_q == WRITE ? latch_q : 'z;
    assign bif.busy = state_q != IDLE;
    assign bif.done = state_q == DONE;

    // Copy sequencer: capture command in IDLE, then alternate READ/WRITE per byte
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            latch_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (!bif.load_en && bif.start) begin
                    src_ptr_q   <= bif.src;
                    dst_ptr_q   <= bif.dst;
                    remaining_q <= bif.count;
                    state_q     <= READ;
                end
                READ: begin
                    latch_q <= src_data;
                    state_q <= WRITE;
                end
                WRITE: begin
                    src_ptr_q   <= src_ptr_q + 1'b1;
                    dst_ptr_q   <= dst_ptr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    state_q     <= remaining_q == '0 ? DONE : READ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
